// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the board-level buttons and the LED pattern generator.
interface led_pattern_gen_if #(parameter int N_LEDS = 5);
  logic [1:0]        mode;
  logic              pause;
  logic              step;
  logic [N_LEDS-1:0] led;
  logic              tick;

  modport master (output mode, pause, step, input led, tick);
  modport slave  (input mode, pause, step, output led, tick);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled up/down counter, bouncing scanner and PWM breathing,
// with pause/single-step for frame-by-frame inspection.
module led_pattern_gen #(
  parameter int N_LEDS    = 5,
  parameter int LOG2DELAY = 21,
  parameter int PWM_BITS  = 8
) (
  input  logic            clk_25mhz,
  input  logic            rst_n,
  led_pattern_gen_if.slave bus
);
  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PW-1:0]       POS_MAX  = PW'(N_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [LOG2DELAY-1:0] r_pre;
  logic [N_LEDS-1:0]    r_cnt, w_cnt_nxt;
  logic [PW-1:0]        r_pos, w_pos_nxt;
  logic                 r_dir, w_dir_nxt;   // 0 = up, 1 = down
  logic [PWM_BITS-1:0]  r_duty, w_duty_nxt;
  logic [PWM_BITS-1:0]  r_pwm;
  logic [1:0]           r_mode_q;
  logic [N_LEDS-1:0]    r_led, w_led_nxt;
  logic                 r_tick;
  logic                 w_mode_chg, w_adv;

  assign w_mode_chg = (bus.mode != r_mode_q);
  // A mode change suppresses any advance landing on the same edge.
  assign w_adv = !w_mode_chg &&
                 ((!bus.pause && (&r_pre)) || (bus.pause && bus.step));

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir;
    w_duty_nxt = r_duty;
    if (w_mode_chg) begin
      w_cnt_nxt  = '0;
      w_pos_nxt  = '0;
      w_dir_nxt  = 1'b0;
      w_duty_nxt = '0;
    end else if (w_adv) begin
      case (r_mode_q)
        2'd0: w_cnt_nxt = r_cnt + 1'b1;
        2'd1: w_cnt_nxt = r_cnt - 1'b1;
        2'd2: begin
          if (N_LEDS > 1) begin
            if (!r_dir) begin
              if (r_pos == POS_MAX) begin
                w_dir_nxt = 1'b1;
                w_pos_nxt = POS_MAX - 1'b1;
              end else begin
                w_pos_nxt = r_pos + 1'b1;
              end
            end else if (r_pos == '0) begin
              w_dir_nxt = 1'b0;
              w_pos_nxt = PW'(1);
            end else begin
              w_pos_nxt = r_pos - 1'b1;
            end
          end
        end
        default: begin
          // Breathing bounces exactly like the scanner, endpoints shown once.
          if (!r_dir) begin
            if (r_duty == DUTY_MAX) begin
              w_dir_nxt  = 1'b1;
              w_duty_nxt = DUTY_MAX - 1'b1;
            end else begin
              w_duty_nxt = r_duty + 1'b1;
            end
          end else if (r_duty == '0) begin
            w_dir_nxt  = 1'b0;
            w_duty_nxt = PWM_BITS'(1);
          end else begin
            w_duty_nxt = r_duty - 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_led_nxt = '0;
    case (r_mode_q)
      2'd0, 2'd1: w_led_nxt = r_cnt;
      2'd2:       w_led_nxt = N_LEDS'(1) << r_pos;
      default:    w_led_nxt = {N_LEDS{r_pwm < r_duty}};
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_cnt    <= '0;
      r_pos    <= '0;
      r_dir    <= 1'b0;
      r_duty   <= '0;
      r_pwm    <= '0;
      r_mode_q <= 2'd0;
      r_led    <= '0;
      r_tick   <= 1'b0;
    end else begin
      if (w_mode_chg)      r_pre <= '0;
      else if (!bus.pause) r_pre <= r_pre + 1'b1;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_pos_nxt;
      r_dir    <= w_dir_nxt;
      r_duty   <= w_duty_nxt;
      r_pwm    <= r_pwm + 1'b1;
      r_mode_q <= bus.mode;
      r_led    <= w_led_nxt;
      r_tick   <= w_adv;
    end
  end

  assign bus.led  = r_led;
  assign bus.tick = r_tick;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: expected LED frames are queued with the stimulus and checked
// one clock after each tick.
module tb_led_pattern_gen;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  led_pattern_gen_if #(.N_LEDS(N)) bus ();

  led_pattern_gen #(.N_LEDS(N), .LOG2DELAY(3), .PWM_BITS(4)) dut (
    .clk_25mhz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  int n_chk = 0, n_pass = 0;
  logic [31:0] sb[$];
  logic mon_en = 1'b0;
  logic prev_tick = 1'b0;
  int tick_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en && prev_tick && sb.size() > 0) chk("led_seq", 32'(bus.led), sb.pop_front());
    if (bus.tick) tick_cnt <= tick_cnt + 1;
    prev_tick <= bus.tick;
  end

  task automatic do_reset(input logic [1:0] m, input logic p);
    mon_en = 1'b0;
    sb.delete();
    bus.mode = m; bus.pause = p; bus.step = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(bus.led), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    rst_n = 1'b1;
  endtask

  task automatic run_until_empty(input string tag, input int bound);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      @(negedge clk); #1; n++;
    end
    chk({"drain_", tag}, 32'(sb.size()), 0);
  endtask

  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!bus.tick && n < bound);
    if (!bus.tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic step_pulse();
    @(negedge clk); bus.step = 1'b1;
    @(negedge clk); bus.step = 1'b0;
  endtask

  task automatic pwm_count(output int hi, output int bad);
    hi = 0; bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.led == '1) hi++;
      else if (bus.led != '0) bad++;
    end
  endtask

  int n, hi, bad, t0;
  logic [31:0] scan_tbl [0:16] = '{2,4,8,16,8,4,2,1,2,4,8,16,8,4,2,1,2};

  initial begin
    bus.mode = 2'd0; bus.pause = 1'b0; bus.step = 1'b0;

    // 1: count up, tick period and full wrap
    do_reset(2'd0, 1'b0);
    for (int i = 0; i < 33; i++) sb.push_back(32'((i + 1) % 32));
    mon_en = 1'b1;
    wait_tick(20, n); chk("first_tick_cyc", n, 8);
    wait_tick(20, n); chk("tick_period", n, 8);
    run_until_empty("up", 8 * 33 + 20);

    // 2: count down wraps from 0 to all ones
    do_reset(2'd1, 1'b0);
    for (int i = 0; i < 10; i++) sb.push_back(32'(31 - i));
    mon_en = 1'b1;
    run_until_empty("down", 120);

    // 3: scanner, endpoints shown once per sweep
    do_reset(2'd2, 1'b0);
    repeat (3) @(negedge clk);
    chk("scan_init", 32'(bus.led), 1);
    for (int i = 0; i < 17; i++) sb.push_back(scan_tbl[i]);
    mon_en = 1'b1;
    run_until_empty("scan", 200);

    // 4: breathing duty 0, 8, 15, then bounce to 14 (paused, stepped)
    do_reset(2'd3, 1'b1);
    repeat (3) @(negedge clk);
    pwm_count(hi, bad); chk("duty0_hi", hi, 0); chk("duty0_bits", bad, 0);
    repeat (8) step_pulse();
    repeat (2) @(negedge clk);
    pwm_count(hi, bad); chk("duty8_hi", hi, 8); chk("duty8_bits", bad, 0);
    repeat (7) step_pulse();
    repeat (2) @(negedge clk);
    pwm_count(hi, bad); chk("duty15_hi", hi, 15);
    step_pulse();
    repeat (2) @(negedge clk);
    pwm_count(hi, bad); chk("duty14_hi", hi, 14);

    // 5: pause at 6, single steps, steps ignored while running
    do_reset(2'd0, 1'b0);
    for (int i = 1; i <= 6; i++) sb.push_back(32'(i));
    mon_en = 1'b1;
    run_until_empty("pre_pause", 80);
    bus.pause = 1'b1;
    t0 = tick_cnt;
    repeat (100) @(negedge clk);
    #1;
    chk("pause_hold", 32'(bus.led), 6);
    chk("pause_ticks", 32'(tick_cnt - t0), 0);
    sb.push_back(7); step_pulse();
    sb.push_back(8); step_pulse();
    run_until_empty("steps", 10);
    chk("step_ticks", 32'(tick_cnt - t0), 2);
    t0 = tick_cnt;
    bus.pause = 1'b0;
    step_pulse(); step_pulse();
    sb.push_back(9);
    run_until_empty("run_step", 30);
    chk("run_step_ticks", 32'(tick_cnt - t0), 1);

    // 6: mode change coinciding with an advance, then async reset mid-scan
    do_reset(2'd0, 1'b0);
    wait_tick(20, n);
    repeat (7) @(negedge clk);
    bus.mode = 2'd2;
    @(negedge clk); #1;
    chk("mc_no_tick", 32'(bus.tick), 0);
    @(negedge clk); #1;
    chk("mc_led", 32'(bus.led), 1);
    sb.push_back(2); sb.push_back(4); sb.push_back(8);
    mon_en = 1'b1;
    wait_tick(20, n); chk("mc_first_adv", n, 7);
    run_until_empty("mc_scan", 40);
    mon_en = 1'b0;
    @(negedge clk); #5;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(bus.led), 0);
    chk("async_rst_tick", 32'(bus.tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
